// File: rtl/ex_stage.sv
// ex_stage -- execute stage of the Lapido pipeline.
//
// Computes the ALU result or memory address for the instruction held in
// ID/EX and registers the EX/MEM values on the falling edge of clock.
// MUL (ALUOp 14) runs on an iterative shift-add multiplier. While it runs,
// stall holds IF/ID/EX upstream.
//
// Ports
//   clock, reset          falling-edge clock, asynchronous active-high reset
//   flush                 squash the instruction in EX (bubble, abort multiply)
//   registerFileDataA/B   operands (B is also the store data)
//   registerFileWrite_in  destination register
//   pcpp                  PC+4, used as the LINK result
//   extendedSignal        sign-extended immediate
//   ALUOp                 operation select
//   memRead_in/memWrite_in load/store flags
//   aluResult, storeData, registerFileWrite, memRead, memWrite  EX/MEM registers
//   stall                 combinational hold request to the hazard logic
//   overflow              (EX_OVERFLOW_EN only) signed overflow of ADD/SUB/ADDI
//
// Optional feature macro: EX_OVERFLOW_EN. When it is defined, a signed overflow
// suppresses the writeback and raises the registered overflow flag.
module ex_stage #(
  parameter int          MUL_CYCLES = 32,
  parameter logic [3:0]  NOP_DEST   = 4'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] registerFileDataA,
  input  logic [31:0] registerFileDataB,
  input  logic [3:0]  registerFileWrite_in,
  input  logic [31:0] pcpp,
  input  logic [31:0] extendedSignal,
  input  logic [4:0]  ALUOp,
  input  logic        memRead_in,
  input  logic        memWrite_in,
  output logic [31:0] aluResult,
  output logic [31:0] storeData,
  output logic [3:0]  registerFileWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        stall
`ifdef EX_OVERFLOW_EN
  ,
  output logic        overflow
`endif
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,
                         OP_OR   = 5'd3,  OP_XOR  = 5'd4,  OP_NOR  = 5'd5,
                         OP_SLT  = 5'd6,  OP_SLTU = 5'd7,  OP_SLL  = 5'd8,
                         OP_SRL  = 5'd9,  OP_SRA  = 5'd10, OP_ADDI = 5'd11,
                         OP_LUI  = 5'd12, OP_MEM  = 5'd13, OP_MUL  = 5'd14,
                         OP_LINK = 5'd15;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mcand_q, mcand_d;   // shifted left each iteration
  logic [31:0]   mplier_q, mplier_d; // shifted right, LSB selects the add
  logic [31:0]   acc_q, acc_d;
  logic [3:0]    mdest_q, mdest_d;

  logic [31:0]   res_q, res_d;
  logic [31:0]   sd_q, sd_d;
  logic [3:0]    rfw_q, rfw_d;
  logic          mr_q, mr_d;
  logic          mw_q, mw_d;

  logic [31:0]   a, b, imm;
  logic [31:0]   sum_ab, diff_ab, sum_ai;
  logic [31:0]   alu_res;

  assign a       = registerFileDataA;
  assign b       = registerFileDataB;
  assign imm     = extendedSignal;
  assign sum_ab  = a + b;
  assign diff_ab = a - b;
  assign sum_ai  = a + imm;

  always_comb begin
    alu_res = '0;
    case (ALUOp)
      OP_ADD:  alu_res = sum_ab;
      OP_SUB:  alu_res = diff_ab;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {31'b0, a < b};
      OP_SLL:  alu_res = a << b[4:0];
      OP_SRL:  alu_res = a >> b[4:0];
      OP_SRA:  alu_res = $signed(a) >>> b[4:0];
      OP_ADDI: alu_res = sum_ai;
      OP_LUI:  alu_res = {imm[15:0], 16'h0};
      OP_MEM:  alu_res = sum_ai;
      OP_LINK: alu_res = pcpp;
      default: alu_res = '0;  // MUL is handled by the FSM; 16-31 yield 0
    endcase
  end

`ifdef EX_OVERFLOW_EN
  logic ov_q, ov_d;
  logic alu_ovf;

  // Signed overflow: operands of equal sign (after negating B for SUB)
  // produce a result of the other sign.
  always_comb begin
    alu_ovf = 1'b0;
    case (ALUOp)
      OP_ADD:  alu_ovf = (a[31] == b[31])   && (sum_ab[31]  != a[31]);
      OP_SUB:  alu_ovf = (a[31] != b[31])   && (diff_ab[31] != a[31]);
      OP_ADDI: alu_ovf = (a[31] == imm[31]) && (sum_ai[31]  != a[31]);
      default: alu_ovf = 1'b0;
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mdest_d  = mdest_q;
    // Bubble by default: no writeback, no memory access, data regs hold.
    res_d    = res_q;
    sd_d     = sd_q;
    rfw_d    = NOP_DEST;
    mr_d     = 1'b0;
    mw_d     = 1'b0;
`ifdef EX_OVERFLOW_EN
    ov_d     = 1'b0;
`endif
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ALUOp == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            mdest_d  = registerFileWrite_in;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_BUSY;
          end else begin
            res_d = alu_res;
            sd_d  = b;
            rfw_d = registerFileWrite_in;
            mr_d  = memRead_in;
            mw_d  = memWrite_in;
`ifdef EX_OVERFLOW_EN
            ov_d  = alu_ovf;
            if (alu_ovf) rfw_d = NOP_DEST;
`endif
          end
        end
        S_BUSY: begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          // The MUL is still presented upstream here; it is not restarted.
          res_d   = acc_q;
          rfw_d   = mdest_q;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mdest_q  <= NOP_DEST;
      res_q    <= '0;
      sd_q     <= '0;
      rfw_q    <= NOP_DEST;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
`ifdef EX_OVERFLOW_EN
      ov_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mdest_q  <= mdest_d;
      res_q    <= res_d;
      sd_q     <= sd_d;
      rfw_q    <= rfw_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
`ifdef EX_OVERFLOW_EN
      ov_q     <= ov_d;
`endif
    end
  end

  assign stall             = ((state_q == S_IDLE) && (ALUOp == OP_MUL)) || (state_q == S_BUSY);
  assign aluResult         = res_q;
  assign storeData         = sd_q;
  assign registerFileWrite = rfw_q;
  assign memRead           = mr_q;
  assign memWrite          = mw_q;
`ifdef EX_OVERFLOW_EN
  assign overflow          = ov_q;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: table of directed vectors, randomized single-cycle
// ops against a reference model, and hand sequences for multiply, flush and
// asynchronous reset.
module tb_ex_stage;

`ifdef EX_OVERFLOW_EN
  localparam bit         OV_EN   = 1'b1;
  localparam logic [3:0] OV_DEST = 4'd0;
`else
  localparam bit         OV_EN   = 1'b0;
  localparam logic [3:0] OV_DEST = 4'd5;
`endif
  localparam logic [3:0] NOP = 4'd0;

  logic        clock, reset, flush;
  logic [31:0] registerFileDataA, registerFileDataB, pcpp, extendedSignal;
  logic [3:0]  registerFileWrite_in;
  logic [4:0]  ALUOp;
  logic        memRead_in, memWrite_in;
  logic [31:0] aluResult, storeData;
  logic [3:0]  registerFileWrite;
  logic        memRead, memWrite, stall;
  logic        ov_out;

  ex_stage #(.MUL_CYCLES(32), .NOP_DEST(4'd0)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .registerFileDataA(registerFileDataA), .registerFileDataB(registerFileDataB),
    .registerFileWrite_in(registerFileWrite_in), .pcpp(pcpp),
    .extendedSignal(extendedSignal), .ALUOp(ALUOp),
    .memRead_in(memRead_in), .memWrite_in(memWrite_in),
    .aluResult(aluResult), .storeData(storeData),
    .registerFileWrite(registerFileWrite), .memRead(memRead),
    .memWrite(memWrite), .stall(stall)
`ifdef EX_OVERFLOW_EN
    , .overflow(ov_out)
`endif
  );
`ifndef EX_OVERFLOW_EN
  assign ov_out = 1'b0;
`endif

  initial clock = 1'b1;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] iv, input logic [31:0] pc, input logic [3:0] d,
                       input logic mr, input logic mw, input logic fl);
    ALUOp = op; registerFileDataA = av; registerFileDataB = bv; extendedSignal = iv;
    pcpp = pc; registerFileWrite_in = d; memRead_in = mr; memWrite_in = mw; flush = fl;
  endtask

  task automatic edge_wait();
    @(negedge clock);
    #1;
  endtask

  // Reference model: plain signed/unsigned arithmetic on wide integers.
  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] av,
                                          input logic [31:0] bv, input logic [31:0] iv,
                                          input logic [31:0] pc);
    longint sa, sb, r;
    int     sh;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    sh = int'(bv % 32);
    r  = 0;
    case (op)
      5'd0:  r = longint'(av) + longint'(bv);
      5'd1:  r = longint'(av) - longint'(bv);
      5'd2:  r = longint'(av & bv);
      5'd3:  r = longint'(av | bv);
      5'd4:  r = longint'(av ^ bv);
      5'd5:  r = longint'(~(av | bv));
      5'd6:  r = (sa < sb) ? 1 : 0;
      5'd7:  r = (longint'(av) < longint'(bv)) ? 1 : 0;
      5'd8:  r = longint'(av) * (longint'(1) << sh);
      5'd9:  r = longint'(av) / (longint'(1) << sh);
      5'd10: r = sa >>> sh;
      5'd11, 5'd13: r = longint'(av) + longint'(iv);
      5'd12: r = longint'(iv % 65536) * 65536;
      5'd15: r = longint'(pc);
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic logic ref_ov(input logic [4:0] op, input logic [31:0] av,
                                  input logic [31:0] bv, input logic [31:0] iv);
    longint s;
    case (op)
      5'd0:  s = longint'($signed(av)) + longint'($signed(bv));
      5'd1:  s = longint'($signed(av)) - longint'($signed(bv));
      5'd11: s = longint'($signed(av)) + longint'($signed(iv));
      default: return 1'b0;
    endcase
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, i, pc;
    logic [3:0]  dest;
    logic        mr, mw;
    logic [31:0] e_res, e_sd;
    logic [3:0]  e_dest;
    logic        e_mr, e_mw, e_ov;
  } vec_t;

  vec_t tbl[12];

  logic [31:0] prev_res, prev_sd;

  initial begin
    int stall_cnt, bub, done_edge;
    logic [31:0] ra, rb, ri, rpc, er;
    logic [4:0]  rop;
    logic [3:0]  rd;
    logic        rmr, rmw, rfl, eov;

    tbl[0]  = '{5'd0,  32'd5, 32'd7, 32'd0, 32'd0, 4'd3, 1'b0, 1'b0, 32'd12, 32'd7, 4'd3, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{5'd13, 32'h100, 32'hAB, 32'hFFFFFFFC, 32'd0, 4'd0, 1'b0, 1'b1, 32'hFC, 32'hAB, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{5'd10, 32'h80000000, 32'd4, 32'd0, 32'd0, 4'd2, 1'b0, 1'b0, 32'hF8000000, 32'd4, 4'd2, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{5'd6,  32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 4'd4, 1'b0, 1'b0, 32'd1, 32'd1, 4'd4, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{5'd7,  32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 4'd4, 1'b0, 1'b0, 32'd0, 32'd1, 4'd4, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{5'd0,  32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 4'd5, 1'b0, 1'b0, 32'h80000000, 32'd1, OV_DEST, 1'b0, 1'b0, OV_EN};
    tbl[6]  = '{5'd12, 32'd9, 32'd0, 32'h00001234, 32'd0, 4'd6, 1'b0, 1'b0, 32'h12340000, 32'd0, 4'd6, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{5'd15, 32'd9, 32'd3, 32'd0, 32'h40, 4'd15, 1'b0, 1'b0, 32'h40, 32'd3, 4'd15, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{5'd20, 32'd9, 32'd3, 32'd0, 32'h40, 4'd7, 1'b0, 1'b0, 32'd0, 32'd3, 4'd7, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{5'd1,  32'd3, 32'd5, 32'd0, 32'd0, 4'd8, 1'b0, 1'b0, 32'hFFFFFFFE, 32'd5, 4'd8, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{5'd13, 32'h200, 32'd0, 32'd8, 32'd0, 4'd4, 1'b1, 1'b0, 32'h208, 32'd0, 4'd4, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{5'd5,  32'd0, 32'd0, 32'd0, 32'd0, 4'd1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd0, 4'd1, 1'b0, 1'b0, 1'b0};

    // Reset state
    reset = 1'b1;
    drive(5'd0, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_res", aluResult, 32'd0);
    chk("rst_sd", storeData, 32'd0);
    chk("rst_dest", {28'd0, registerFileWrite}, {28'd0, NOP});
    chk("rst_mrmw", {30'd0, memRead, memWrite}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    #1 reset = 1'b0;
    edge_wait();

    // Directed table
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].i, tbl[k].pc, tbl[k].dest,
            tbl[k].mr, tbl[k].mw, 1'b0);
      #1 chk($sformatf("tbl%0d_stall", k), {31'd0, stall}, 32'd0);
      edge_wait();
      chk($sformatf("tbl%0d_res", k), aluResult, tbl[k].e_res);
      chk($sformatf("tbl%0d_sd", k), storeData, tbl[k].e_sd);
      chk($sformatf("tbl%0d_dest", k), {28'd0, registerFileWrite}, {28'd0, tbl[k].e_dest});
      chk($sformatf("tbl%0d_mrmw", k), {30'd0, memRead, memWrite}, {30'd0, tbl[k].e_mr, tbl[k].e_mw});
      chk($sformatf("tbl%0d_ov", k), {31'd0, ov_out}, {31'd0, tbl[k].e_ov});
    end
    prev_res = tbl[11].e_res;
    prev_sd  = tbl[11].e_sd;

    // Randomized single-cycle ops with occasional flush
    for (int k = 0; k < 300; k++) begin
      rop = 5'($urandom_range(0, 31));
      if (rop == 5'd14) rop = 5'd0;
      ra  = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      ri  = $urandom;
      rpc = $urandom;
      rd  = 4'($urandom);
      rmr = 1'($urandom);
      rmw = 1'($urandom);
      rfl = ($urandom_range(0, 7) == 0);
      drive(rop, ra, rb, ri, rpc, rd, rmr, rmw, rfl);
      edge_wait();
      if (rfl) begin
        chk("rnd_flush_res", aluResult, prev_res);
        chk("rnd_flush_sd", storeData, prev_sd);
        chk("rnd_flush_dest", {28'd0, registerFileWrite}, {28'd0, NOP});
        chk("rnd_flush_mrmw", {30'd0, memRead, memWrite}, 32'd0);
        chk("rnd_flush_ov", {31'd0, ov_out}, 32'd0);
      end else begin
        er  = ref_res(rop, ra, rb, ri, rpc);
        eov = OV_EN && ref_ov(rop, ra, rb, ri);
        chk($sformatf("rnd_res op%0d", rop), aluResult, er);
        chk("rnd_sd", storeData, rb);
        chk("rnd_dest", {28'd0, registerFileWrite}, {28'd0, eov ? NOP : rd});
        chk("rnd_mrmw", {30'd0, memRead, memWrite}, {30'd0, rmr, rmw});
        chk("rnd_ov", {31'd0, ov_out}, {31'd0, eov});
        prev_res = er;
        prev_sd  = rb;
      end
    end

    // MUL 1234*5678: 33 stall cycles, 33 bubbles, product on edge 34
    drive(5'd14, 32'd1234, 32'd5678, 0, 0, 4'd9, 1'b0, 1'b0, 1'b0);
    #1;
    stall_cnt = 0; bub = 0; done_edge = 0;
    for (int k = 1; k <= 40 && done_edge == 0; k++) begin
      if (stall) stall_cnt++;
      edge_wait();
      if (registerFileWrite == 4'd9) done_edge = k;
      else if (registerFileWrite == NOP && !memRead && !memWrite) bub++;
      if (k == 5) chk("mul_bubble_hold", aluResult, prev_res);
      if (k == 1) begin
        registerFileDataA = $urandom;   // captured copies must be used
        registerFileDataB = $urandom;
        #1;
      end
    end
    chk("mul_done_edge", done_edge, 32'd34);
    chk("mul_stall_cycles", stall_cnt, 32'd33);
    chk("mul_bubbles", bub, 32'd33);
    chk("mul_product", aluResult, 32'd1234 * 32'd5678);
    chk("mul_mrmw", {30'd0, memRead, memWrite}, 32'd0);

    // Upstream advances: the next op runs normally, no restart
    drive(5'd0, 32'd20, 32'd22, 0, 0, 4'd2, 1'b0, 1'b0, 1'b0);
    #1 chk("after_mul_stall", {31'd0, stall}, 32'd0);
    edge_wait();
    chk("after_mul_res", aluResult, 32'd42);
    chk("after_mul_dest", {28'd0, registerFileWrite}, 32'd2);

    // Flush at counter==10: capture edge + 10 busy edges
    drive(5'd14, 32'd3, 32'd4, 0, 0, 4'd7, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 11; k++) edge_wait();
    chk("flush_pre_stall", {31'd0, stall}, 32'd1);
    drive(5'd0, 32'd1, 32'd1, 0, 0, 4'd6, 1'b0, 1'b0, 1'b1);
    edge_wait();
    chk("flush_bubble_dest", {28'd0, registerFileWrite}, {28'd0, NOP});
    chk("flush_bubble_res", aluResult, 32'd42);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    flush = 1'b0;
    edge_wait();
    chk("flush_add_res", aluResult, 32'd2);
    chk("flush_add_dest", {28'd0, registerFileWrite}, 32'd6);

    // Flush beats a new MUL in IDLE: no multiply is launched
    drive(5'd14, 32'd5, 32'd6, 0, 0, 4'd8, 1'b0, 1'b0, 1'b1);
    edge_wait();
    chk("flush_mul_dest", {28'd0, registerFileWrite}, {28'd0, NOP});
    drive(5'd0, 32'd4, 32'd4, 0, 0, 4'd1, 1'b0, 1'b0, 1'b0);
    #1 chk("flush_mul_stall", {31'd0, stall}, 32'd0);
    edge_wait();
    chk("flush_mul_next", aluResult, 32'd8);

    // Asynchronous reset mid-BUSY
    drive(5'd13, 32'h10, 32'h55, 32'h4, 0, 4'd3, 1'b1, 1'b1, 1'b0);
    edge_wait();
    drive(5'd14, 32'd7, 32'd8, 0, 0, 4'd10, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) edge_wait();
    #2;
    reset = 1'b1;
    ALUOp = 5'd0;
    #1;
    chk("arst_res", aluResult, 32'd0);
    chk("arst_sd", storeData, 32'd0);
    chk("arst_dest", {28'd0, registerFileWrite}, {28'd0, NOP});
    chk("arst_mrmw", {30'd0, memRead, memWrite}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    #1 reset = 1'b0;
    drive(5'd0, 32'd9, 32'd1, 0, 0, 4'd11, 1'b0, 1'b0, 1'b0);
    edge_wait();
    chk("arst_recover", aluResult, 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
